// File: rtl/i2s_audio_rx_pkg.sv
// Shared types for the I2S receive front-end: slot-tracking FSM states and bit-counter width.
package i2s_audio_rx_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_e;

  // Counts up to 32 bit positions per slot, with one spare code for saturation.
  localparam int CNT_W = $clog2(32) + 1;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchroniser for one asynchronous I2S line, plus a registered rising-edge strobe.
// q is delayed one extra stage so it lines up with rise; every instance has identical latency.
module i2s_sync_edge (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      q    <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      q    <= s2_q;
      rise <= s2_q & ~q;
    end
  end

endmodule

// File: rtl/i2s_audio_rx.sv
// I2S receiver: deserialises the left channel into signed Q(int_out_p).(frac_out_p) samples.
// Define I2S_STEREO_AVG_EN to emit the (L+R)>>>1 average once per frame instead of the left word.
module i2s_audio_rx
  import i2s_audio_rx_pkg::*;
#(
  parameter int int_out_p      = 1,
  parameter int frac_out_p     = 11,
  parameter int sample_width_p = 24
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  input  logic                            i2s_bclk_i,
  input  logic                            i2s_lrclk_i,
  input  logic                            i2s_sdata_i,
  output logic [int_out_p+frac_out_p-1:0] audio_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic                            overrun_o,
  output logic                            frame_err_o,
  output logic [1:0]                      dbg_state_o
);

  localparam int W = int_out_p + frac_out_p;

  logic bclk_rise, bclk_level_unused;
  logic ws, sd_bit, ws_rise_unused, sd_rise_unused;

  i2s_sync_edge u_bclk  (.clk_i(clk_i), .reset_ni(reset_ni), .d(i2s_bclk_i),
                         .q(bclk_level_unused), .rise(bclk_rise));
  i2s_sync_edge u_lrclk (.clk_i(clk_i), .reset_ni(reset_ni), .d(i2s_lrclk_i),
                         .q(ws), .rise(ws_rise_unused));
  i2s_sync_edge u_sdata (.clk_i(clk_i), .reset_ni(reset_ni), .d(i2s_sdata_i),
                         .q(sd_bit), .rise(sd_rise_unused));

  state_e                    state_q, state_d;
  logic                      ws_prev_q;
  logic [CNT_W-1:0]          bit_idx_q;
  logic [sample_width_p-1:0] shreg_q, shift_next;
  logic                      ws_chg, capturing, word_done, short_slot, emit;
  logic [W-1:0]              word_top, emit_data;

  // The bit on the rise that reveals a ws change still belongs to the old slot.
  assign shift_next = {shreg_q[sample_width_p-2:0], sd_bit};
  assign ws_chg     = bclk_rise && (ws != ws_prev_q);
  assign capturing  = (state_q != SYNC) && (bit_idx_q < CNT_W'(sample_width_p));
  assign word_done  = bclk_rise && capturing && (bit_idx_q == CNT_W'(sample_width_p - 1));
  assign short_slot = ws_chg && (state_q != SYNC) && (bit_idx_q < CNT_W'(sample_width_p - 1));
  assign word_top   = shift_next[sample_width_p-1 -: W];
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    if (ws_chg) begin
      case (state_q)
        SYNC:    if (!ws) state_d = LEFT;
        LEFT:    if (ws)  state_d = RIGHT;
        RIGHT:   if (!ws) state_d = LEFT;
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= SYNC;
      ws_prev_q <= 1'b0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (bclk_rise) begin
        ws_prev_q <= ws;
        if (ws_chg) begin
          bit_idx_q <= '0;
        end else if (capturing) begin
          bit_idx_q <= bit_idx_q + CNT_W'(1);
          shreg_q   <= shift_next;
        end
      end
    end
  end

`ifdef I2S_STEREO_AVG_EN
  logic [W-1:0] left_q;
  logic         left_ok_q;
  logic [W:0]   pair_sum;

  // Sign-extended W+1 bit sum; dropping the LSB is an arithmetic shift toward -inf.
  assign pair_sum  = {left_q[W-1], left_q} + {word_top[W-1], word_top};
  assign emit      = word_done && (state_q == RIGHT) && left_ok_q;
  assign emit_data = pair_sum[W:1];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      left_q    <= '0;
      left_ok_q <= 1'b0;
    end else if (ws_chg && (state_d == LEFT)) begin
      left_ok_q <= 1'b0;
    end else if (word_done && (state_q == LEFT)) begin
      left_q    <= word_top;
      left_ok_q <= 1'b1;
    end
  end
`else
  assign emit      = word_done && (state_q == LEFT);
  assign emit_data = word_top;
`endif

  // Valid/ready: audio_o is held stable while valid_o=1; a transfer happens on any posedge
  // with valid_o & ready_i. A new word replaces a word being transferred that same cycle,
  // and is dropped (overrun) only if the held word is not being transferred.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      audio_o     <= '0;
      valid_o     <= 1'b0;
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (short_slot) frame_err_o <= 1'b1;
      if (emit) begin
        if (valid_o && !ready_i) begin
          overrun_o <= 1'b1;
        end else begin
          audio_o <= emit_data;
          valid_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Bench for i2s_audio_rx: I2S BFM at clk/8 with 32-bit slots, slot-level reference model.
module tb_i2s_audio_rx;

  localparam int W  = 12;
  localparam int SW = 24;

  // clock / reset
  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk = ~clk;

  logic         bclk = 1'b0, lrclk = 1'b0, sdata = 1'b0, ready = 1'b1;
  logic [W-1:0] audio;
  logic         valid, overrun, frame_err;
  logic [1:0]   dbg_state;

  i2s_audio_rx dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .i2s_bclk_i  (bclk),
    .i2s_lrclk_i (lrclk),
    .i2s_sdata_i (sdata),
    .audio_o     (audio),
    .valid_o     (valid),
    .ready_i     (ready),
    .overrun_o   (overrun),
    .frame_err_o (frame_err),
    .dbg_state_o (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  bit ws_q[$];
  bit bit_q[$];

  // reference model state (slot granularity)
  bit m_synced, m_prev_ws, m_pend_counted, m_exp_ferr, m_exp_ovr, m_hold_full;
  int m_pend_bits;
  bit hold_ready = 1'b0;
  bit rand_ready = 1'b0;
`ifdef I2S_STEREO_AVG_EN
  logic [W-1:0] m_left;
  bit m_left_ok;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_synced = 0; m_prev_ws = 0; m_pend_counted = 0; m_pend_bits = 0;
    m_exp_ferr = 0; m_exp_ovr = 0; m_hold_full = 0;
`ifdef I2S_STEREO_AVG_EN
    m_left_ok = 0;
`endif
  endfunction

  function automatic void model_emit(input logic [W-1:0] v);
    if (hold_ready && m_hold_full) m_exp_ovr = 1;
    else begin
      exp_q.push_back(v);
      if (hold_ready) m_hold_full = 1;
    end
  endfunction

  // Queue one channel slot (ch: 0=left) and update the expected outputs.
  task automatic push_slot(input bit ch, input logic [SW-1:0] word, input int nbits);
    logic [W-1:0] top;
    bit counted;
    top = word[SW-1 -: W];
    for (int i = 0; i < nbits; i++) begin
      ws_q.push_back(ch);
      bit_q.push_back(i < SW ? word[SW-1-i] : 1'($urandom_range(0, 1)));
    end
    if (ch != m_prev_ws) begin
      if (m_pend_counted && m_pend_bits < SW) m_exp_ferr = 1;
      if (m_prev_ws && !ch) m_synced = 1;
    end
    m_prev_ws = ch;
    counted = m_synced;
    m_pend_counted = counted;
    m_pend_bits = nbits;
`ifdef I2S_STEREO_AVG_EN
    if (!ch) m_left_ok = 0;
    if (counted && nbits >= SW) begin
      if (!ch) begin
        m_left = top;
        m_left_ok = 1;
      end else if (m_left_ok) begin
        int s;
        s = (int'($signed(m_left)) + int'($signed(top))) >>> 1;
        model_emit(W'(s));
      end
    end
`else
    if (counted && nbits >= SW && !ch) model_emit(top);
`endif
  endtask

  // Drive queued bits; ws leads data by one bit. Without flush the last bit waits for its successor.
  task automatic tx(input bit flush);
    while (bit_q.size() > (flush ? 0 : 1)) begin
      bclk  = 1'b0;
      sdata = bit_q[0];
      lrclk = (ws_q.size() > 1) ? ws_q[1] : ws_q[0];
      #40;
      bclk = 1'b1;
      #40;
      void'(bit_q.pop_front());
      void'(ws_q.pop_front());
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    check_eq({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic check_flags(input string tag);
    #1;
    check_eq({tag, "_frame_err"}, frame_err, m_exp_ferr);
    check_eq({tag, "_overrun"}, overrun, m_exp_ovr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_audio"}, audio, 0);
    check_eq({tag, "_valid"}, valid, 0);
    check_eq({tag, "_overrun"}, overrun, 0);
    check_eq({tag, "_frame_err"}, frame_err, 0);
    check_eq({tag, "_state"}, dbg_state, 0);
  endtask

  // scoreboard: every transfer must match the head of the expected queue
  always @(negedge clk) begin
    if (reset_ni && valid && ready) begin
      if (exp_q.size() != 0) check_eq("sample", audio, exp_q.pop_front());
      else check_eq("spurious_valid", valid, 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5ms;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset_ni = 1'b1;
    @(posedge clk);

    // directed values, leading right slot gives the sync edge
    push_slot(1, 24'($urandom), 32);
    push_slot(0, 24'h400000, 32); push_slot(1, 24'($urandom), 32);
    push_slot(0, 24'hC00000, 32); push_slot(1, 24'($urandom), 32);
    push_slot(0, 24'hFFFFFF, 32); push_slot(1, 24'($urandom), 32);
    tx(0);
    drain("directed");
    check_flags("directed");

    // random words with random backpressure gaps
    rand_ready = 1'b1;
    for (int f = 0; f < 12; f++) begin
      push_slot(0, 24'($urandom), 32);
      push_slot(1, 24'($urandom), 32);
    end
    tx(0);
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    ready = 1'b1;
    drain("random");
    check_flags("random");

    // reset in the middle of a left slot
    push_slot(0, 24'h123456, 12);
    tx(1);
    reset_ni = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    model_reset();
    repeat (3) @(posedge clk);
    reset_ni = 1'b1;
    push_slot(1, 24'($urandom), 32);
    push_slot(0, 24'h654321, 32); push_slot(1, 24'($urandom), 32);
    tx(0);
    drain("post_reset");
    check_flags("post_reset");

    // output register full across two frames
    ready = 1'b0;
    hold_ready = 1'b1;
    push_slot(0, 24'h100000, 32); push_slot(1, 24'($urandom), 32);
    push_slot(0, 24'h200000, 32); push_slot(1, 24'($urandom), 32);
    tx(0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("bp_audio_held", audio, 12'h100);
    check_eq("bp_valid_held", valid, 1);
    check_eq("bp_overrun", overrun, m_exp_ovr);
    ready = 1'b1;
    hold_ready = 1'b0;
    m_hold_full = 0;
    drain("backpressure");
    #1;
    check_eq("bp_valid_clear", valid, 0);

    // short left slot
    push_slot(0, 24'($urandom), 10); push_slot(1, 24'($urandom), 32);
    push_slot(0, 24'h400000, 32);    push_slot(1, 24'($urandom), 32);
    tx(0);
    drain("short_slot");
    check_flags("short_slot");

    // pair values that distinguish left-only from stereo average
    push_slot(0, 24'h400000, 32); push_slot(1, 24'hC00000, 32);
    push_slot(0, 24'h7FFFFF, 32); push_slot(1, 24'h7FFFFF, 32);
    tx(1);
    drain("pair");
    check_flags("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
